// File: rtl/mesh_term_rx.sv
// mesh_term_rx -- terminal sink for one output port of the 4x4 mesh router.
//
// Drains the router output FIFO via pndng/data_out/pop. Each word's target
// {row,col} is compared with this terminal's {ROW_ID,COL_ID} or the
// broadcast ID. Matching words go into a local FIFO for a local consumer.
// Misrouted words are dropped and counted in a saturating error counter.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high reset
//   pndng     in   router output FIFO non-empty
//   data_out  in   router output FIFO head word [pck_sz]
//   pop       out  one-cycle pulse that consumes the router head word
//   rd_en     in   local consumer read request
//   rd_data   out  registered head of the local FIFO [pck_sz]
//   rd_valid  out  local FIFO non-empty
//   full      out  local FIFO full
//   err_cnt   out  dropped misrouted packets, saturating [16]
//
// Optional feature (macro RX_STATS_EN):
//   rx_cnt     out  accepted packet count, wraps [32]
//   bcast_seen out  sticky flag, set on the first accepted broadcast
//
// Pop timing: IDLE -> POP -> SETTLE -> IDLE. The SETTLE cycle gives the router
// time to update pndng/data_out. At most one packet is accepted every 3 cycles.
module mesh_term_rx #(
  parameter int         pck_sz     = 41,
  parameter int         fifo_depth = 4,
  parameter logic [3:0] ROW_ID     = 4'd0,
  parameter logic [3:0] COL_ID     = 4'd0,
  parameter logic [7:0] broadcast  = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pndng,
  input  logic [pck_sz-1:0] data_out,
  output logic              pop,
  input  logic              rd_en,
  output logic [pck_sz-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic [15:0]       err_cnt
`ifdef RX_STATS_EN
  ,
  output logic [31:0]       rx_cnt,
  output logic              bcast_seen
`endif
);

  localparam int AW = $clog2(fifo_depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(fifo_depth);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POP    = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [pck_sz-1:0] mem_r [fifo_depth];
  logic [AW-1:0]     wr_ptr_r, rd_ptr_r, rd_ptr_nxt_s;
  logic [CW-1:0]     count_r, count_nxt_s, count_after_rd_s;
  logic [pck_sz-1:0] rd_data_r, head_nxt_s;
  logic [15:0]       err_cnt_r;
  logic [7:0]        addr_s;
  logic              pop_r, rd_valid_r, full_r;
  logic              rd_s, wr_s, err_s, match_s, bcast_s;

  // Address decode and FIFO read/write qualification.
  always_comb begin
    addr_s  = data_out[pck_sz-9:pck_sz-16];
    bcast_s = (addr_s == broadcast);
    match_s = (addr_s == {ROW_ID, COL_ID}) || bcast_s;
    rd_s    = rd_en && (count_r != {CW{1'b0}});
    wr_s    = (state_r == POP) && match_s;
    err_s   = (state_r == POP) && !match_s;
    count_after_rd_s = count_r - {{(CW-1){1'b0}}, rd_s};
  end

  // Next-state logic for the pop handshake FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        // The slot freed by a read on this same edge counts as free.
        if (pndng && (count_after_rd_s < DEPTH_C)) begin
          state_nxt_s = POP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      POP:     state_nxt_s = SETTLE;
      SETTLE:  state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next FIFO occupancy, read pointer and registered head value.
  always_comb begin
    case ({wr_s, rd_s})
      2'b10:   count_nxt_s = count_r + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_nxt_s = count_r - {{(CW-1){1'b0}}, 1'b1};
      default: count_nxt_s = count_r;
    endcase
    if (rd_s) begin
      rd_ptr_nxt_s = rd_ptr_r + AW'(1'b1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    // The slot written on this edge is not in mem_r yet. Bypass it when it
    // becomes the new head.
    if (wr_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
      head_nxt_s = data_out;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // FSM state, pop pulse, FIFO control and error counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      pop_r      <= 1'b0;
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      rd_valid_r <= 1'b0;
      full_r     <= 1'b0;
      rd_data_r  <= {pck_sz{1'b0}};
      err_cnt_r  <= 16'd0;
    end else begin
      state_r    <= state_nxt_s;
      pop_r      <= (state_nxt_s == POP);
      rd_ptr_r   <= rd_ptr_nxt_s;
      count_r    <= count_nxt_s;
      rd_valid_r <= (count_nxt_s != {CW{1'b0}});
      full_r     <= (count_nxt_s == DEPTH_C);
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (count_nxt_s != {CW{1'b0}}) begin
        rd_data_r <= head_nxt_s;
      end
      if (err_s && (err_cnt_r != 16'hFFFF)) begin
        err_cnt_r <= err_cnt_r + 16'd1;
      end
    end
  end

  // Local FIFO storage. It needs no reset because the count gates every read.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= data_out;
    end
  end

`ifdef RX_STATS_EN
  logic [31:0] rx_cnt_r;
  logic        bcast_seen_r;

  // Accepted-packet counter and the sticky broadcast flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_cnt_r     <= 32'd0;
      bcast_seen_r <= 1'b0;
    end else begin
      if (wr_s) begin
        rx_cnt_r <= rx_cnt_r + 32'd1;
      end
      if (wr_s && bcast_s) begin
        bcast_seen_r <= 1'b1;
      end
    end
  end

  assign rx_cnt     = rx_cnt_r;
  assign bcast_seen = bcast_seen_r;
`endif

  assign pop      = pop_r;
  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign full     = full_r;
  assign err_cnt  = err_cnt_r;

endmodule

// File: tb/tb_mesh_term_rx.sv
// Directed bench for mesh_term_rx. The terminal is configured as (1,2) with
// a 4-entry local FIFO.
// A queue models the router output FIFO. The posedge process consumes the
// head word on pop. The stimulus initial block drives pndng/data_out from
// that queue at each falling edge.
module tb_mesh_term_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pndng = 1'b0;
  logic [40:0] data_out = 41'd0;
  logic        pop;
  logic        rd_en = 1'b0;
  logic [40:0] rd_data;
  logic        rd_valid;
  logic        full;
  logic [15:0] err_cnt;
`ifdef RX_STATS_EN
  logic [31:0] rx_cnt;
  logic        bcast_seen;
`endif

  int total = 0;
  int bad = 0;

  logic [40:0] q[$];
  int          pop_cnt = 0;
  int          consec = 0;
  int          cyc = 0;
  int          pop_cyc[$];
  logic        prev_pop = 1'b0;

  mesh_term_rx #(
    .pck_sz(41), .fifo_depth(4), .ROW_ID(4'd1), .COL_ID(4'd2), .broadcast(8'hFF)
  ) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .data_out(data_out), .pop(pop),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .full(full),
    .err_cnt(err_cnt)
`ifdef RX_STATS_EN
    , .rx_cnt(rx_cnt), .bcast_seen(bcast_seen)
`endif
  );

  always #5 clk = ~clk;

  // Router output FIFO: consume the head word on each pop and track pop spacing.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    prev_pop <= pop;
    if (pop) begin
      if (q.size() != 0) void'(q.pop_front());
      pop_cnt <= pop_cnt + 1;
      pop_cyc.push_back(cyc);
      if (prev_pop) consec <= consec + 1;
    end
  end

  function automatic logic [40:0] pk(input logic [3:0] r, input logic [3:0] c,
                                     input logic [23:0] pl);
    return {8'h00, r, c, 1'b0, pl};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, then present the router head word.
  task automatic step();
    @(negedge clk);
    pndng    = (q.size() != 0);
    data_out = (q.size() != 0) ? q[0] : 41'd0;
  endtask

  task automatic wait_pop(input string tag);
    int n;
    n = 0;
    step();
    while (pop !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({tag, "_pop"}, 64'(pop), 64'd1);
  endtask

  initial begin
    int base;
    int n;

    // Reset state.
    step(); step();
    check("rst_pop", 64'(pop), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    reset = 1'b0;

    // 1: matching packet is accepted.
    q.push_back(pk(4'd1, 4'd2, 24'hABCDEF));
    wait_pop("t1");
    step();
    check("t1_pop_pulse", 64'(pop), 64'd0);
    check("t1_rd_valid", 64'(rd_valid), 64'd1);
    check("t1_rd_data", 64'(rd_data), 64'(pk(4'd1, 4'd2, 24'hABCDEF)));
    check("t1_err_cnt", 64'(err_cnt), 64'd0);
    rd_en = 1'b1; step(); rd_en = 1'b0;
    check("t1_drained", 64'(rd_valid), 64'd0);

    // 2: misrouted packet is dropped.
    q.push_back(pk(4'd3, 4'd0, 24'h123456));
    wait_pop("t2");
    step();
    check("t2_err_cnt", 64'(err_cnt), 64'd1);
    check("t2_rd_valid", 64'(rd_valid), 64'd0);

    // 3: broadcast packet is accepted.
    q.push_back(pk(4'hF, 4'hF, 24'h00BEEF));
    wait_pop("t3");
    step();
    check("t3_rd_data", 64'(rd_data), 64'(pk(4'hF, 4'hF, 24'h00BEEF)));
    check("t3_err_cnt", 64'(err_cnt), 64'd1);
`ifdef RX_STATS_EN
    check("t3_rx_cnt", 64'(rx_cnt), 64'd2);
    check("t3_bcast_seen", 64'(bcast_seen), 64'd1);
`endif
    rd_en = 1'b1; step(); rd_en = 1'b0;
    check("t3_drained", 64'(rd_valid), 64'd0);

    // 4: a full local FIFO blocks further pops.
    base = pop_cnt;
    for (int i = 0; i < 6; i++) q.push_back(pk(4'd1, 4'd2, 24'(i)));
    for (int i = 0; i < 30; i++) step();
    check("t4_pops", 64'(pop_cnt - base), 64'd4);
    check("t4_full", 64'(full), 64'd1);
    n = pop_cyc.size();
    check("t4_gap1", 64'(pop_cyc[n-3] - pop_cyc[n-4]), 64'd3);
    check("t4_gap2", 64'(pop_cyc[n-2] - pop_cyc[n-3]), 64'd3);
    check("t4_gap3", 64'(pop_cyc[n-1] - pop_cyc[n-2]), 64'd3);
    rd_en = 1'b1; step(); rd_en = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("t4_fifth_pop", 64'(pop_cnt - base), 64'd5);
    check("t4_full_again", 64'(full), 64'd1);
    check("t4_head", 64'(rd_data), 64'(pk(4'd1, 4'd2, 24'd1)));
    rd_en = 1'b1;
    for (int i = 0; i < 20; i++) step();
    rd_en = 1'b0;
    step();
    check("t4_all_pops", 64'(pop_cnt - base), 64'd6);
    check("t4_empty", 64'(rd_valid), 64'd0);
    check("t4_no_consec_pop", 64'(consec), 64'd0);

    // 5: reset asserted during the POP cycle.
    q.push_back(pk(4'd1, 4'd2, 24'h000005));
    wait_pop("t5");
    #2 reset = 1'b1;
    #1;
    check("t5_pop_async", 64'(pop), 64'd0);
    check("t5_rd_valid", 64'(rd_valid), 64'd0);
    check("t5_err_cnt", 64'(err_cnt), 64'd0);
`ifdef RX_STATS_EN
    check("t5_rx_cnt", 64'(rx_cnt), 64'd0);
`endif
    step(); step();
    reset = 1'b0;
    wait_pop("t5_resume");
    step();
    check("t5_rd_data", 64'(rd_data), 64'(pk(4'd1, 4'd2, 24'h000005)));
    rd_en = 1'b1; step(); rd_en = 1'b0;

    // 6: error counter saturates. Preload it near the top to keep the run short.
    force dut.err_cnt_r = 16'hFFFD;
    step();
    release dut.err_cnt_r;
    base = pop_cnt;
    for (int i = 0; i < 4; i++) q.push_back(pk(4'd7, 4'd7, 24'(i)));
    for (int i = 0; i < 20; i++) step();
    check("t6_pops", 64'(pop_cnt - base), 64'd4);
    check("t6_err_sat", 64'(err_cnt), 64'hFFFF);
    check("t6_rd_valid", 64'(rd_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
